// File: rtl/pudding_chain_bank.sv
// Shift chain with a bank of state registers: LANES bits per strobe into a CHAIN_W-bit chain,
// committed to or reloaded from one of BANKS registers, with frame-length guarding on commits.
module pudding_chain_bank #(
  parameter int unsigned CHAIN_W = 128,
  parameter int unsigned LANES   = 1,
  parameter int unsigned BANKS   = 2,
  parameter int unsigned OUT_W   = 8,
  localparam int unsigned FRAME  = CHAIN_W / LANES,
  localparam int unsigned CW     = $clog2(FRAME + 1),
  localparam int unsigned BW     = (BANKS > 1) ? $clog2(BANKS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [LANES-1:0] din,
  input  logic             shift,
  input  logic             transfer,
  input  logic             dir,
  input  logic [BW-1:0]    bank_sel,
  input  logic             stateen,
  input  logic             clr_err,
  output logic [OUT_W-1:0] chain_top,
  output logic [OUT_W-1:0] state_top,
  output logic [OUT_W-1:0] state_oe,
  output logic [CW-1:0]    shift_cnt,
  output logic             frame_full,
  output logic             xfer_err
);

  logic [CHAIN_W-1:0] chain_q, chain_d;
  logic [CHAIN_W-1:0] bank_q [BANKS];
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               err_q, err_d;
  logic [CHAIN_W-1:0] sel_bank;
  logic               sel_ok;
  logic               full;
  logic               commit_ok;

  // Out-of-range selects read as zero rather than aliasing onto a real bank.
  always_comb begin
    sel_bank = '0;
    for (int b = 0; b < BANKS; b++) begin
      if (bank_sel == BW'(b)) sel_bank = bank_q[b];
    end
  end

  assign sel_ok    = 32'(bank_sel) < BANKS;
  assign full      = (cnt_q == CW'(FRAME));
  assign commit_ok = transfer & dir & full & sel_ok;

  always_comb begin
    chain_d = chain_q;
    cnt_d   = cnt_q;
    err_d   = err_q & ~clr_err;
    if (transfer) begin
      if (!sel_ok || (dir && !full)) begin
        err_d = 1'b1;
      end else if (!dir) begin
        chain_d = sel_bank;
        cnt_d   = CW'(FRAME);
      end else begin
        cnt_d   = '0;
      end
    end else if (shift) begin
      chain_d = {chain_q[CHAIN_W-LANES-1:0], din};
      if (!full) cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      chain_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      for (int b = 0; b < BANKS; b++) bank_q[b] <= '0;
    end else if (ena) begin
      chain_q <= chain_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      for (int b = 0; b < BANKS; b++) begin
        if (commit_ok && bank_sel == BW'(b)) bank_q[b] <= chain_q;
      end
    end
  end

  assign chain_top  = chain_q[CHAIN_W-1 -: OUT_W];
  assign state_top  = stateen ? sel_bank[CHAIN_W-1 -: OUT_W] : '0;
  assign state_oe   = {OUT_W{stateen}};
  assign shift_cnt  = cnt_q;
  assign frame_full = full;
  assign xfer_err   = err_q;

endmodule

// File: tb/tb_pudding_chain_bank.sv
// Directed and random checks of pudding_chain_bank: default build plus a LANES=4, BANKS=3 build.
module tb_pudding_chain_bank;

  logic       clk = 1'b0;
  logic       rst = 1'b0, ena = 1'b1, shift = 1'b0, transfer = 1'b0, dir = 1'b0;
  logic       stateen = 1'b0, clr_err = 1'b0;
  logic       din = 1'b0, bank_sel = 1'b0;
  logic [3:0] din4 = 4'h0;
  logic [1:0] bank_sel4 = 2'd0;

  logic [7:0] chain_top, state_top, state_oe, shift_cnt;
  logic       frame_full, xfer_err;
  logic [7:0] chain_top4, state_top4, state_oe4;
  logic [5:0] shift_cnt4;
  logic       frame_full4, xfer_err4;

  int n_chk = 0;
  int n_fail = 0;

  localparam logic [127:0] Pat = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;

  always #5 clk = ~clk;

  pudding_chain_bank u_dut (
    .clk(clk), .rst(rst), .ena(ena), .din(din), .shift(shift), .transfer(transfer),
    .dir(dir), .bank_sel(bank_sel), .stateen(stateen), .clr_err(clr_err),
    .chain_top(chain_top), .state_top(state_top), .state_oe(state_oe),
    .shift_cnt(shift_cnt), .frame_full(frame_full), .xfer_err(xfer_err)
  );

  pudding_chain_bank #(.CHAIN_W(128), .LANES(4), .BANKS(3), .OUT_W(8)) u_dut4 (
    .clk(clk), .rst(rst), .ena(ena), .din(din4), .shift(shift), .transfer(transfer),
    .dir(dir), .bank_sel(bank_sel4), .stateen(stateen), .clr_err(clr_err),
    .chain_top(chain_top4), .state_top(state_top4), .state_oe(state_oe4),
    .shift_cnt(shift_cnt4), .frame_full(frame_full4), .xfer_err(xfer_err4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; ena = 1'b1; shift = 1'b0; transfer = 1'b0; clr_err = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic shift_bit(input logic b);
    din = b;
    shift = 1'b1;
    step();
    shift = 1'b0;
  endtask

  task automatic xfer(input logic d, input logic [1:0] sel);
    dir = d; bank_sel = sel[0]; bank_sel4 = sel;
    transfer = 1'b1;
    step();
    transfer = 1'b0;
  endtask

  task automatic test_reset();
    stateen = 1'b0;
    do_reset();
    n_chk++; if (chain_top !== 8'h00) begin n_fail++; $display("FAIL reset chain_top: got %h want 00", chain_top); end
    n_chk++; if (shift_cnt !== 8'd0) begin n_fail++; $display("FAIL reset shift_cnt: got %0d want 0", shift_cnt); end
    n_chk++; if (frame_full !== 1'b0) begin n_fail++; $display("FAIL reset frame_full: got %b want 0", frame_full); end
    n_chk++; if (xfer_err !== 1'b0) begin n_fail++; $display("FAIL reset xfer_err: got %b want 0", xfer_err); end
    n_chk++; if (state_oe !== 8'h00) begin n_fail++; $display("FAIL reset state_oe: got %h want 00", state_oe); end
  endtask

  task automatic test_shift_frame();
    for (int i = 0; i < 127; i++) shift_bit(Pat[127-i]);
    n_chk++; if (frame_full !== 1'b0) begin n_fail++; $display("FAIL frame127 frame_full: got %b want 0", frame_full); end
    n_chk++; if (shift_cnt !== 8'd127) begin n_fail++; $display("FAIL frame127 shift_cnt: got %0d want 127", shift_cnt); end
    shift_bit(Pat[0]);
    n_chk++; if (chain_top !== 8'h01) begin n_fail++; $display("FAIL frame chain_top: got %h want 01", chain_top); end
    n_chk++; if (shift_cnt !== 8'd128) begin n_fail++; $display("FAIL frame shift_cnt: got %0d want 128", shift_cnt); end
    n_chk++; if (frame_full !== 1'b1) begin n_fail++; $display("FAIL frame frame_full: got %b want 1", frame_full); end
    n_chk++; if (xfer_err !== 1'b0) begin n_fail++; $display("FAIL frame xfer_err: got %b want 0", xfer_err); end
  endtask

  task automatic test_commit();
    xfer(1'b1, 2'd1);
    n_chk++; if (shift_cnt !== 8'd0) begin n_fail++; $display("FAIL commit shift_cnt: got %0d want 0", shift_cnt); end
    n_chk++; if (chain_top !== 8'h01) begin n_fail++; $display("FAIL commit chain_top: got %h want 01", chain_top); end
    stateen = 1'b1; bank_sel = 1'b1; #1;
    n_chk++; if (state_top !== 8'h01) begin n_fail++; $display("FAIL commit bank1 state_top: got %h want 01", state_top); end
    n_chk++; if (state_oe !== 8'hFF) begin n_fail++; $display("FAIL commit state_oe: got %h want ff", state_oe); end
    bank_sel = 1'b0; #1;
    n_chk++; if (state_top !== 8'h00) begin n_fail++; $display("FAIL commit bank0 state_top: got %h want 00", state_top); end
  endtask

  task automatic test_reject_err();
    for (int i = 0; i < 5; i++) shift_bit(1'b1);
    xfer(1'b1, 2'd0);
    n_chk++; if (xfer_err !== 1'b1) begin n_fail++; $display("FAIL early_commit xfer_err: got %b want 1", xfer_err); end
    n_chk++; if (shift_cnt !== 8'd5) begin n_fail++; $display("FAIL early_commit shift_cnt: got %0d want 5", shift_cnt); end
    n_chk++; if (chain_top !== 8'h24) begin n_fail++; $display("FAIL early_commit chain_top: got %h want 24", chain_top); end
    n_chk++; if (state_top !== 8'h00) begin n_fail++; $display("FAIL early_commit bank0 state_top: got %h want 00", state_top); end
    clr_err = 1'b1;
    xfer(1'b1, 2'd0);
    clr_err = 1'b0;
    n_chk++; if (xfer_err !== 1'b1) begin n_fail++; $display("FAIL set_beats_clear xfer_err: got %b want 1", xfer_err); end
    clr_err = 1'b1; step(); clr_err = 1'b0;
    n_chk++; if (xfer_err !== 1'b0) begin n_fail++; $display("FAIL clr_err xfer_err: got %b want 0", xfer_err); end
  endtask

  task automatic test_reload();
    for (int i = 0; i < 10; i++) shift_bit(1'($urandom));
    xfer(1'b0, 2'd1);
    n_chk++; if (chain_top !== 8'h01) begin n_fail++; $display("FAIL reload chain_top: got %h want 01", chain_top); end
    n_chk++; if (frame_full !== 1'b1) begin n_fail++; $display("FAIL reload frame_full: got %b want 1", frame_full); end
    n_chk++; if (shift_cnt !== 8'd128) begin n_fail++; $display("FAIL reload shift_cnt: got %0d want 128", shift_cnt); end
    xfer(1'b1, 2'd0);
    bank_sel = 1'b0; #1;
    n_chk++; if (xfer_err !== 1'b0) begin n_fail++; $display("FAIL reload_commit xfer_err: got %b want 0", xfer_err); end
    n_chk++; if (state_top !== 8'h01) begin n_fail++; $display("FAIL reload_commit bank0 state_top: got %h want 01", state_top); end
    n_chk++; if (shift_cnt !== 8'd0) begin n_fail++; $display("FAIL reload_commit shift_cnt: got %0d want 0", shift_cnt); end
  endtask

  task automatic test_ena_hold();
    xfer(1'b1, 2'd0);
    n_chk++; if (xfer_err !== 1'b1) begin n_fail++; $display("FAIL ena_pre xfer_err: got %b want 1", xfer_err); end
    ena = 1'b0;
    for (int i = 0; i < 4; i++) shift_bit(1'b1);
    clr_err = 1'b1;
    xfer(1'b0, 2'd1);
    clr_err = 1'b0;
    n_chk++; if (shift_cnt !== 8'd0) begin n_fail++; $display("FAIL ena_hold shift_cnt: got %0d want 0", shift_cnt); end
    n_chk++; if (chain_top !== 8'h01) begin n_fail++; $display("FAIL ena_hold chain_top: got %h want 01", chain_top); end
    n_chk++; if (xfer_err !== 1'b1) begin n_fail++; $display("FAIL ena_hold xfer_err: got %b want 1", xfer_err); end
    ena = 1'b1;
    clr_err = 1'b1; step(); clr_err = 1'b0;
    for (int i = 0; i < 63; i++) shift_bit(1'b1);
    n_chk++; if (shift_cnt !== 8'd63) begin n_fail++; $display("FAIL pre_rst shift_cnt: got %0d want 63", shift_cnt); end
    rst = 1'b1;
    shift_bit(1'b1);
    rst = 1'b0;
    n_chk++; if (shift_cnt !== 8'd0) begin n_fail++; $display("FAIL mid_rst shift_cnt: got %0d want 0", shift_cnt); end
    n_chk++; if (chain_top !== 8'h00) begin n_fail++; $display("FAIL mid_rst chain_top: got %h want 00", chain_top); end
    stateen = 1'b1;
    bank_sel = 1'b0; #1;
    n_chk++; if (state_top !== 8'h00) begin n_fail++; $display("FAIL mid_rst bank0: got %h want 00", state_top); end
    bank_sel = 1'b1; #1;
    n_chk++; if (state_top !== 8'h00) begin n_fail++; $display("FAIL mid_rst bank1: got %h want 00", state_top); end
  endtask

  task automatic test_lanes4();
    do_reset();
    din4 = 4'hA;
    for (int i = 0; i < 31; i++) begin shift = 1'b1; step(); end
    shift = 1'b0;
    n_chk++; if (frame_full4 !== 1'b0) begin n_fail++; $display("FAIL l4_31 frame_full: got %b want 0", frame_full4); end
    n_chk++; if (shift_cnt4 !== 6'd31) begin n_fail++; $display("FAIL l4_31 shift_cnt: got %0d want 31", shift_cnt4); end
    shift = 1'b1; step(); shift = 1'b0;
    n_chk++; if (frame_full4 !== 1'b1) begin n_fail++; $display("FAIL l4_32 frame_full: got %b want 1", frame_full4); end
    n_chk++; if (shift_cnt4 !== 6'd32) begin n_fail++; $display("FAIL l4_32 shift_cnt: got %0d want 32", shift_cnt4); end
    n_chk++; if (chain_top4 !== 8'hAA) begin n_fail++; $display("FAIL l4 chain_top: got %h want aa", chain_top4); end
    xfer(1'b1, 2'd3);
    stateen = 1'b1; bank_sel4 = 2'd3; #1;
    n_chk++; if (xfer_err4 !== 1'b1) begin n_fail++; $display("FAIL l4_sel3 xfer_err: got %b want 1", xfer_err4); end
    n_chk++; if (state_top4 !== 8'h00) begin n_fail++; $display("FAIL l4_sel3 state_top: got %h want 00", state_top4); end
    n_chk++; if (state_oe4 !== 8'hFF) begin n_fail++; $display("FAIL l4_sel3 state_oe: got %h want ff", state_oe4); end
    n_chk++; if (shift_cnt4 !== 6'd32) begin n_fail++; $display("FAIL l4_sel3 shift_cnt: got %0d want 32", shift_cnt4); end
    xfer(1'b1, 2'd2);
    bank_sel4 = 2'd2; #1;
    n_chk++; if (state_top4 !== 8'hAA) begin n_fail++; $display("FAIL l4_sel2 state_top: got %h want aa", state_top4); end
    n_chk++; if (shift_cnt4 !== 6'd0) begin n_fail++; $display("FAIL l4_sel2 shift_cnt: got %0d want 0", shift_cnt4); end
    bank_sel4 = 2'd0; #1;
    n_chk++; if (state_top4 !== 8'h00) begin n_fail++; $display("FAIL l4_sel0 state_top: got %h want 00", state_top4); end
  endtask

  task automatic test_priority();
    do_reset();
    for (int i = 0; i < 128; i++) shift_bit(1'(i % 2));
    n_chk++; if (chain_top !== 8'h55) begin n_fail++; $display("FAIL prio_pre chain_top: got %h want 55", chain_top); end
    din = 1'b1; shift = 1'b1;
    xfer(1'b1, 2'd0);
    shift = 1'b0;
    stateen = 1'b1; bank_sel = 1'b0; #1;
    n_chk++; if (chain_top !== 8'h55) begin n_fail++; $display("FAIL prio_commit chain_top: got %h want 55", chain_top); end
    n_chk++; if (shift_cnt !== 8'd0) begin n_fail++; $display("FAIL prio_commit shift_cnt: got %0d want 0", shift_cnt); end
    n_chk++; if (state_top !== 8'h55) begin n_fail++; $display("FAIL prio_commit bank0: got %h want 55", state_top); end
    shift = 1'b1;
    xfer(1'b0, 2'd0);
    shift = 1'b0;
    n_chk++; if (chain_top !== 8'h55) begin n_fail++; $display("FAIL prio_reload chain_top: got %h want 55", chain_top); end
    n_chk++; if (shift_cnt !== 8'd128) begin n_fail++; $display("FAIL prio_reload shift_cnt: got %0d want 128", shift_cnt); end
  endtask

  task automatic test_random();
    logic [127:0] m_chain;
    logic [127:0] m_bank [2];
    int           m_cnt;
    logic         m_err, n_err;
    logic [7:0]   exp_st;
    do_reset();
    m_chain = '0; m_bank[0] = '0; m_bank[1] = '0; m_cnt = 0; m_err = 1'b0;
    for (int op = 0; op < 500; op++) begin
      int r;
      r = int'($urandom_range(0, 99));
      rst      = (r < 2);
      transfer = (r >= 2 && r < 22);
      shift    = ($urandom_range(0, 3) != 0);
      ena      = ($urandom_range(0, 9) != 0);
      dir      = 1'($urandom);
      bank_sel = 1'($urandom);
      din      = 1'($urandom);
      clr_err  = ($urandom_range(0, 15) == 0);
      stateen  = 1'($urandom);
      if (rst) begin
        m_chain = '0; m_bank[0] = '0; m_bank[1] = '0; m_cnt = 0; m_err = 1'b0;
      end else if (ena) begin
        n_err = m_err && !clr_err;
        if (transfer) begin
          if (dir) begin
            if (m_cnt == 128) begin m_bank[bank_sel] = m_chain; m_cnt = 0; end
            else n_err = 1'b1;
          end else begin
            m_chain = m_bank[bank_sel];
            m_cnt = 128;
          end
        end else if (shift) begin
          m_chain = {m_chain[126:0], din};
          if (m_cnt < 128) m_cnt++;
        end
        m_err = n_err;
      end
      step();
      exp_st = stateen ? m_bank[bank_sel][127:120] : 8'h00;
      n_chk++; if (chain_top !== m_chain[127:120]) begin n_fail++; $display("FAIL rand op%0d chain_top: got %h want %h", op, chain_top, m_chain[127:120]); end
      n_chk++; if (shift_cnt !== 8'(m_cnt)) begin n_fail++; $display("FAIL rand op%0d shift_cnt: got %0d want %0d", op, shift_cnt, m_cnt); end
      n_chk++; if (frame_full !== (m_cnt == 128)) begin n_fail++; $display("FAIL rand op%0d frame_full: got %b want %b", op, frame_full, m_cnt == 128); end
      n_chk++; if (xfer_err !== m_err) begin n_fail++; $display("FAIL rand op%0d xfer_err: got %b want %b", op, xfer_err, m_err); end
      n_chk++; if (state_top !== exp_st) begin n_fail++; $display("FAIL rand op%0d state_top: got %h want %h", op, state_top, exp_st); end
    end
    idle();
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_shift_frame();
    test_commit();
    test_reject_err();
    test_reload();
    test_ena_hold();
    test_lanes4();
    test_priority();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pudding_chain_bank.md
Name: pudding_chain_bank

Overview:
- Parametrised successor to the PUDDING daisychain/state block.
- A CHAIN_W-bit shift chain is loaded LANES bits per shift strobe.
- The chain commits to, or reloads from, one of BANKS state registers.
- A frame counter blocks commits of partially shifted frames and raises a sticky error. The top OUT_W bits of the chain and of the selected bank drive the tile's dedicated and bidirectional pins.

Parameters:
- CHAIN_W, 128, chain and state register width; must be a multiple of LANES.
- LANES, 1, bits shifted in per shift strobe; 1, 2, 4 or 8.
- BANKS, 2, number of state registers; 1..8, need not be a power of 2.
- OUT_W, 8, width of the observation outputs; must be <= CHAIN_W.
- Derived: FRAME = CHAIN_W/LANES; CW = $clog2(FRAME+1); BW = max(1, $clog2(BANKS)).

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- ena  in  1  tile enable; when low, all registers hold.
- din  in  LANES  shift data; din[LANES-1] is the oldest bit.
- shift  in  1  shift strobe.
- transfer  in  1  transfer strobe; has priority over shift.
- dir  in  1  1 = chain->bank (commit), 0 = bank->chain (reload).
- bank_sel  in  BW  bank used for transfers and for state_top.
- stateen  in  1  gates state_top and state_oe.
- clr_err  in  1  clears xfer_err.
- chain_top  out  OUT_W  chain[CHAIN_W-1 -: OUT_W].
- state_top  out  OUT_W  bank[bank_sel][CHAIN_W-1 -: OUT_W] when stateen=1, else 0.
- state_oe  out  OUT_W  all ones when stateen=1, else 0.
- shift_cnt  out  CW  shifts since the last commit, reload or reset; saturates at FRAME.
- frame_full  out  1  shift_cnt == FRAME.
- xfer_err  out  1  sticky rejected-transfer flag.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge): chain, all banks, shift_cnt and xfer_err are cleared to 0. rst overrides ena and all strobes.
- Priority per edge: rst > !ena (hold everything, including xfer_err) > transfer > shift > idle.
- Shift (shift=1, transfer=0):
  - chain <= {chain[CHAIN_W-LANES-1:0], din}.
  - shift_cnt <= min(shift_cnt+1, FRAME).
  - Shifting continues when full; shift_cnt stays at FRAME.
- Commit (transfer=1, dir=1):
  - Accepted only when frame_full=1 and bank_sel < BANKS.
  - On accept: bank[bank_sel] <= chain, shift_cnt <= 0, chain unchanged.
  - On reject: no register changes except xfer_err <= 1.
- Reload (transfer=1, dir=0):
  - Accepted when bank_sel < BANKS: chain <= bank[bank_sel], shift_cnt <= FRAME.
  - On reject (bank_sel out of range): xfer_err <= 1, nothing else changes.
- Error flag: clr_err clears xfer_err. If clr_err and a new rejection occur in the same cycle, set wins.
- Latency:
  - chain_top, shift_cnt, frame_full and xfer_err are registered; they reflect an edge's update immediately after that edge.
  - state_top and state_oe are combinational from bank_sel and stateen, through the registered banks.
- bank_sel >= BANKS with stateen=1: state_top = 0.
- Banks not addressed by a commit hold their value.
- shift=0 and transfer=0: chain and shift_cnt hold.
- Reset asserted mid-frame discards the partial frame and all banks.
- No shift data reaches any bank without a full FRAME of shifts, or a reload, since the last commit.

Test Plan:
- Defaults, reset then 128 shifts, MSB first, of 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210 -> chain_top=8'h01, shift_cnt=128, frame_full=1, xfer_err=0.
- Commit to bank 1 (dir=1, bank_sel=1), then stateen=1 -> state_top=8'h01 with bank_sel=1 and 8'h00 with bank_sel=0; state_oe=8'hFF; shift_cnt=0.
- After the commit, 5 shifts of 1 then a commit to bank 0 -> xfer_err=1, bank 0 state_top stays 8'h00, shift_cnt=5. Then clr_err=1 together with another early commit -> xfer_err stays 1. Then clr_err alone -> xfer_err=0.
- Reload from bank 1 after 10 random shifts -> chain_top=8'h01, frame_full=1. An immediate commit to bank 0 is accepted -> bank 0 state_top=8'h01.
- LANES=4, BANKS=3: 32 strobes of din=4'hA -> chain_top=8'hAA, frame_full=1 at strobe 32. Commit with bank_sel=3 -> xfer_err=1 and state_top=0.
- Defaults, ena=0 during 4 shift strobes -> shift_cnt and chain_top unchanged. rst=1 at shift 64 -> shift_cnt=0, chain_top=0, all banks read 0.
- Defaults, transfer=1 and shift=1 in the same cycle -> only the transfer takes effect.
- Random 500-op mix checked against a reference model -> zero mismatches.
